// File: rtl/clk_edge_monitor.sv
// Edge detector and period monitor for an external divided clock sampled in the clk_in domain.
// Period stability is tracked by an UNLOCKED / ACQUIRE / LOCKED state machine with loss detection.
module clk_edge_monitor #(
   parameter int EXP_PERIOD = 4,
   parameter int TOL        = 1,
   parameter int LOCK_COUNT = 8,
   parameter int TIMEOUT    = 16
) (
   input  logic       clk_in,
   input  logic       reset,
   input  logic       clk_ext,
   output logic       rise_pulse,
   output logic       fall_pulse,
   output logic [7:0] period,
   output logic       period_valid,
   output logic       locked,
   output logic       lost_pulse
);

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      ACQUIRE  = 2'd1,
      LOCKED   = 2'd2
   } state_t;

   localparam int LO_INT = (EXP_PERIOD > TOL) ? (EXP_PERIOD - TOL) : 0;
   localparam int HI_INT = ((EXP_PERIOD + TOL) > 255) ? 255 : (EXP_PERIOD + TOL);
   localparam int TO_INT = (TIMEOUT > 255) ? 255 : ((TIMEOUT < 1) ? 1 : TIMEOUT);
   localparam int LC_INT = (LOCK_COUNT > 15) ? 15 : ((LOCK_COUNT < 1) ? 1 : LOCK_COUNT);

   localparam logic [7:0] PER_LO   = LO_INT[7:0];
   localparam logic [7:0] PER_HI   = HI_INT[7:0];
   localparam logic [7:0] TO_LIM   = TO_INT[7:0];
   localparam logic [3:0] LOCK_LIM = LC_INT[3:0];

   logic       s1, s2, s3;
   logic [1:0] fill;
   logic       rise, fall, good, timeout;
   logic [7:0] cnt, cnt_next;
   logic [3:0] gcnt, gcnt_next, gcnt_inc;
   state_t     state, state_next;
   logic [7:0] period_next;
   logic       period_valid_next, lost_next;

   // Two-flop synchronizer plus history flop; fill records how many real samples have entered the chain.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         s3   <= 1'b0;
         fill <= 2'd0;
      end else begin
         s1 <= clk_ext;
         s2 <= s1;
         s3 <= s2;
         if (fill != 2'd3) begin
            fill <= fill + 2'd1;
         end
      end
   end

   // Edges count only once s3 holds a genuine sample, so a high level at reset release is no rise.
   assign rise     = s2 & ~s3 & (fill == 2'd3);
   assign fall     = ~s2 & s3 & (fill == 2'd3);
   assign good     = (cnt >= PER_LO) && (cnt <= PER_HI);
   assign timeout  = ~rise & (cnt >= TO_LIM);
   assign gcnt_inc = (gcnt == 4'hF) ? gcnt : (gcnt + 4'd1);
   assign cnt_next = rise ? 8'd1 : ((cnt == 8'hFF) ? cnt : (cnt + 8'd1));

   // Lock tracking; a rise in the same cycle as the timeout threshold takes priority over the timeout.
   always_comb begin
      state_next        = state;
      gcnt_next         = gcnt;
      period_next       = period;
      period_valid_next = period_valid;
      lost_next         = 1'b0;
      if (rise) begin
         if (state == UNLOCKED) begin
            state_next = ACQUIRE;
            gcnt_next  = 4'd0;
         end else begin
            period_next       = cnt;
            period_valid_next = 1'b1;
            if (good) begin
               if (state == ACQUIRE) begin
                  gcnt_next = gcnt_inc;
                  if (gcnt_inc >= LOCK_LIM) begin
                     state_next = LOCKED;
                  end
               end
            end else begin
               gcnt_next = 4'd0;
               if (state == LOCKED) begin
                  state_next = ACQUIRE;
                  lost_next  = 1'b1;
               end
            end
         end
      end else if (timeout) begin
         state_next        = UNLOCKED;
         period_valid_next = 1'b0;
         lost_next         = (state == LOCKED);
      end
   end

   // All outputs are registered so they change together one cycle after the detected edge.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state        <= UNLOCKED;
         cnt          <= 8'd0;
         gcnt         <= 4'd0;
         period       <= 8'd0;
         period_valid <= 1'b0;
         locked       <= 1'b0;
         lost_pulse   <= 1'b0;
         rise_pulse   <= 1'b0;
         fall_pulse   <= 1'b0;
      end else begin
         state        <= state_next;
         cnt          <= cnt_next;
         gcnt         <= gcnt_next;
         period       <= period_next;
         period_valid <= period_valid_next;
         locked       <= (state_next == LOCKED);
         lost_pulse   <= lost_next;
         rise_pulse   <= rise;
         fall_pulse   <= fall;
      end
   end

endmodule
